// File: rtl/qadd_pipe_if.sv
// Operand/result bundle for the signed-magnitude fixed-point adder.
// The master drives operands and start; the slave returns the sum and its status.
interface qadd_pipe_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic         done_flag;
    logic         overflow;

    modport master (
        output start, a, b,
        input  c, done_flag, overflow
    );

    modport slave (
        input  start, a, b,
        output c, done_flag, overflow
    );
endinterface

// File: rtl/qadd_pipe.sv
// Pipelined signed-magnitude fixed-point adder with a saturating magnitude.
// Ranks: sorted operands, computed result, registered outputs (start at edge k -> c after edge k+2).
module qadd_pipe #(
    parameter int N = 32,
    parameter int Q = 23
) (
    input  logic           clk,
    input  logic           rst_n,
    qadd_pipe_if.slave     bus
);
    localparam int M = N - 1;  // magnitude width

    if (Q < 0 || Q > M) begin : g_bad_q
        $error("qadd_pipe: Q must lie within the magnitude field");
    end

    // ---------------- stage 1: split, normalise -0, sort by magnitude
    logic [M-1:0] a_mag, b_mag;
    logic         a_sgn, b_sgn, a_ge_b;
    logic [M-1:0] large_d, small_d, large_q, small_q;
    logic         sign_d, same_d, v1_d;
    logic         sign_q, same_q, v1_q;

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        a_mag   = bus.a[M-1:0];
        b_mag   = bus.b[M-1:0];
        a_sgn   = bus.a[M] & (|a_mag);
        b_sgn   = bus.b[M] & (|b_mag);
        a_ge_b  = (a_mag >= b_mag);
        large_d = a_ge_b ? a_mag : b_mag;
        small_d = a_ge_b ? b_mag : a_mag;
        sign_d  = a_ge_b ? a_sgn : b_sgn;
        same_d  = (a_sgn == b_sgn);
        v1_d    = bus.start;
    end

    // NOTE: sequential state uses non-blocking assignments so all ranks update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            large_q <= '0;
            small_q <= '0;
            sign_q  <= 1'b0;
            same_q  <= 1'b0;
        end else begin
            v1_q <= v1_d;
            if (bus.start) begin
                large_q <= large_d;
                small_q <= small_d;
                sign_q  <= sign_d;
                same_q  <= same_d;
            end
        end
    end

    // ---------------- stage 2: add or subtract the sorted magnitudes
    logic [N-1:0] sum;
    logic [M-1:0] diff;
    logic [M-1:0] mag_d;
    logic         sgn_d, ovf_d, v2_d;
    logic [N-1:0] res_q;
    logic         ovf2_q, v2_q;

    always_comb begin
        sum  = {1'b0, large_q} + {1'b0, small_q};
        diff = large_q - small_q;  // large >= small, so this never wraps
        v2_d = v1_q;
        if (same_q) begin
            ovf_d = sum[M];
            mag_d = sum[M] ? {M{1'b1}} : sum[M-1:0];
            sgn_d = sign_q;
        end else begin
            ovf_d = 1'b0;
            mag_d = diff;
            sgn_d = sign_q & (|diff);  // an exact cancel is always +0
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            res_q  <= '0;
            ovf2_q <= 1'b0;
        end else begin
            v2_q <= v2_d;
            if (v1_q) begin
                res_q  <= {sgn_d, mag_d};
                ovf2_q <= ovf_d;
            end
        end
    end

    // ---------------- output rank: c and overflow hold between completions
    logic [N-1:0] c_q;
    logic         done_q, ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q    <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= v2_q;
            if (v2_q) begin
                c_q   <= res_q;
                ovf_q <= ovf2_q;
            end
        end
    end

    assign bus.c         = c_q;
    assign bus.done_flag = done_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_qadd_pipe.sv
// Directed bench for qadd_pipe: hand-computed Q8.23 vectors, latency, pipelining and reset.
module tb_qadd_pipe;
    localparam int N = 32;
    localparam int Q = 23;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    qadd_pipe_if #(.N(N)) bus ();

    qadd_pipe #(.N(N), .Q(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
    endtask

    // One isolated operation: done must appear exactly after the second edge past sampling.
    task automatic single(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] ec, input logic eo);
        drive(a, b);
        tick();                       // edge k samples
        bus.start = 1'b0;
        check({tag, "_done_k"}, 32'(bus.done_flag), 32'd0);
        tick();                       // edge k+1
        check({tag, "_done_k1"}, 32'(bus.done_flag), 32'd0);
        tick();                       // edge k+2
        check({tag, "_done"}, 32'(bus.done_flag), 32'd1);
        check({tag, "_c"}, bus.c, ec);
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
        tick();
        check({tag, "_done_off"}, 32'(bus.done_flag), 32'd0);
        check({tag, "_c_hold"}, bus.c, ec);
        check({tag, "_ovf_hold"}, 32'(bus.overflow), 32'(eo));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check("rst_c", bus.c, 32'h0);
        check("rst_done", 32'(bus.done_flag), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_done", 32'(bus.done_flag), 32'd0);
        end

        single("same_pos",   32'h0080_0000, 32'h0040_0000, 32'h00C0_0000, 1'b0);
        single("same_neg",   32'h8080_0000, 32'h8040_0000, 32'h80C0_0000, 1'b0);
        single("mixed",      32'h0080_0000, 32'h80C0_0000, 32'h8040_0000, 1'b0);
        single("cancel",     32'h0080_0000, 32'h8080_0000, 32'h0000_0000, 1'b0);
        single("edge_fit",   32'h4000_0000, 32'h3FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        single("sat_pos",    32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
        single("sat_neg",    32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
        single("negz_negz",  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
        single("negz_neg",   32'h8000_0000, 32'h8000_0005, 32'h8000_0005, 1'b0);
        single("pos_negz",   32'h0000_0005, 32'h8000_0000, 32'h0000_0005, 1'b0);

        // Back-to-back starts
        drive(32'h0080_0000, 32'h0080_0000);
        tick();
        drive(32'h0100_0000, 32'h8040_0000);
        tick();
        check("pipe_done_early", 32'(bus.done_flag), 32'd0);
        drive(32'h0000_0000, 32'h0000_0000);
        tick();
        bus.start = 1'b0;
        check("pipe0_done", 32'(bus.done_flag), 32'd1);
        check("pipe0_c", bus.c, 32'h0100_0000);
        tick();
        check("pipe1_done", 32'(bus.done_flag), 32'd1);
        check("pipe1_c", bus.c, 32'h00C0_0000);
        tick();
        check("pipe2_done", 32'(bus.done_flag), 32'd1);
        check("pipe2_c", bus.c, 32'h0000_0000);
        tick();
        check("pipe_done_end", 32'(bus.done_flag), 32'd0);

        // Leave a nonzero saturated result, then reset asynchronously mid-cycle
        single("pre_rst", 32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_c", bus.c, 32'h0);
        check("async_rst_done", 32'(bus.done_flag), 32'd0);
        check("async_rst_ovf", 32'(bus.overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_done", 32'(bus.done_flag), 32'd0);
        end

        // Reset while an operation is in flight: it must vanish
        begin
            int pulses;
            pulses = 0;
            drive(32'h0080_0000, 32'h0040_0000);
            tick();
            bus.start = 1'b0;
            tick();
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (bus.done_flag === 1'b1) pulses++;
            end
            check("flight_pulses", 32'(pulses), 32'd0);
            check("flight_c", bus.c, 32'h0);
            check("flight_ovf", 32'(bus.overflow), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
